// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the handshaked RISC-V data memory.
package data_memory_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int MAX_LATENCY = 15;

  // Natural alignment only: halves on even lanes, words on lane 0.
  function automatic logic misaligned(size_e sz, logic [1:0] lane);
    case (sz)
      SZ_H:    return lane[0];
      SZ_W:    return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_lsu_align.sv
// Combinational store byte-merge and load extract/extend for one 32-bit word.
module lsu_align
  import data_memory_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  size_e       size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] store_word_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  always_comb begin
    store_word_o = word_i;
    case (size_i)
      SZ_B:    store_word_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_H:    store_word_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: store_word_o = wdata_i;
    endcase

    // Bring the addressed lane down to bit 0 before extending.
    shifted     = word_i >> {lane_i, 3'b000};
    load_data_o = word_i;
    case (size_i)
      SZ_B:    load_data_o = uns_i ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data_o = uns_i ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Parametrised data memory with byte/half/word access, wait-state FSM and error response.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int    ADDR_W    = 32,
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = "data.mem"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  logic [31:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        lane_q, lane_d;
  size_e             size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;

  size_e             req_sz;
  logic              accept, exec, req_err;
  logic              e_we, e_uns, e_err;
  logic [IDX_W-1:0]  e_idx;
  logic [1:0]        e_lane;
  size_e             e_size;
  logic [31:0]       e_wdata, rd_word, st_word, ld_data;

  assign req_sz    = size_e'(req_size);
  assign req_ready = rst && (state_q != BUSY);
  assign accept    = req_valid && req_ready;
  assign req_err   = (req_sz == SZ_BAD) || misaligned(req_sz, req_addr[1:0])
                     || ((req_addr >> (IDX_W + 2)) != '0);

  // Zero wait states execute on the accept edge straight from the request pins.
  if (LATENCY == 0) begin : g_direct
    assign e_we    = req_we;
    assign e_uns   = req_unsigned;
    assign e_err   = req_err;
    assign e_idx   = req_addr[IDX_W+1:2];
    assign e_lane  = req_addr[1:0];
    assign e_size  = req_sz;
    assign e_wdata = req_wdata;
    assign exec    = accept;
  end else begin : g_captured
    assign e_we    = we_q;
    assign e_uns   = uns_q;
    assign e_err   = err_q;
    assign e_idx   = idx_q;
    assign e_lane  = lane_q;
    assign e_size  = size_q;
    assign e_wdata = wdata_q;
    assign exec    = (state_q == BUSY) && (cnt_q == '0);
  end

  assign rd_word = mem[e_idx];

  lsu_align u_align (
    .word_i       (rd_word),
    .lane_i       (e_lane),
    .size_i       (e_size),
    .uns_i        (e_uns),
    .wdata_i      (e_wdata),
    .store_word_o (st_word),
    .load_data_o  (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = exec;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    we_d        = accept ? req_we : we_q;
    uns_d       = accept ? req_unsigned : uns_q;
    err_d       = accept ? req_err : err_q;
    idx_d       = accept ? req_addr[IDX_W+1:2] : idx_q;
    lane_d      = accept ? req_addr[1:0] : lane_q;
    size_d      = accept ? req_sz : size_q;
    wdata_d     = accept ? req_wdata : wdata_q;

    case (state_q)
      BUSY: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        if (!accept)           state_d = IDLE;
        else if (LATENCY == 0) state_d = RESP;
        else begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
    endcase

    if (exec) begin
      rsp_err_d   = e_err;
      rsp_rdata_d = (e_err || e_we) ? 32'h0 : ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    uns_q   <= uns_d;
    err_q   <= err_d;
    idx_q   <= idx_d;
    lane_q  <= lane_d;
    size_q  <= size_d;
    wdata_q <= wdata_d;
  end

  // Array is never reset so its image survives rst.
  always_ff @(posedge clk) begin
    if (exec && e_we && !e_err) mem[e_idx] <= st_word;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory.sv
// Randomised bench for data_memory: two instances (2 and 0 wait states) checked against a byte-level model.
module tb_data_memory;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] wd;
    int          due;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       rv = '0, rwe = '0, runs = '0;
  logic [1:0][31:0] raddr = '0, rwd = '0;
  logic [1:0][1:0]  rsz = '0;

  logic rdy0, rdy1, vld0, vld1, err0, err1;
  logic [31:0] rd0, rd1;
  logic [1:0] rdy, rvld, rerr;
  logic [1:0][31:0] rdata;
  assign rdy   = {rdy1, rdy0};
  assign rvld  = {vld1, vld0};
  assign rerr  = {err1, err0};
  assign rdata = {rd1, rd0};

  data_memory #(.ADDR_W(32), .DEPTH(16), .LATENCY(2), .INIT_FILE("")) u_l2 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy0), .req_we(rwe[0]),
    .req_addr(raddr[0]), .req_size(rsz[0]), .req_unsigned(runs[0]), .req_wdata(rwd[0]),
    .rsp_valid(vld0), .rsp_rdata(rd0), .rsp_err(err0));

  data_memory #(.ADDR_W(32), .DEPTH(16), .LATENCY(0), .INIT_FILE("")) u_l0 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy1), .req_we(rwe[1]),
    .req_addr(raddr[1]), .req_size(rsz[1]), .req_unsigned(runs[1]), .req_wdata(rwd[1]),
    .rsp_valid(vld1), .rsp_rdata(rd1), .rsp_err(err1));

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Byte-level reference: a DEPTH=16 word memory seen as bytes.
  function automatic void model_op(input op_t o, input logic [31:0] w,
                                   output logic [31:0] nw, output logic [31:0] rd, output logic er);
    int nbytes, lane;
    longint v;
    logic [7:0] b [4];
    nbytes = (o.sz == 2'd0) ? 1 : (o.sz == 2'd1) ? 2 : 4;
    lane   = int'(o.addr % 4);
    er     = (o.sz == 2'd3) || (lane % nbytes != 0) || (o.addr >= 32'd64);
    nw     = w;
    rd     = 32'h0;
    if (er) return;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    if (o.we) begin
      for (int i = 0; i < nbytes; i++) b[lane+i] = o.wd[8*i +: 8];
      nw = {b[3], b[2], b[1], b[0]};
    end else begin
      v = 0;
      for (int i = nbytes - 1; i >= 0; i--) v = v * 256 + longint'(b[lane+i]);
      if (!o.uns && nbytes < 4 && v >= (longint'(1) << (8*nbytes - 1)))
        v = v - (longint'(1) << (8*nbytes));
      rd = v[31:0];
    end
  endfunction

  logic [31:0] mm [2][16];
  op_t         pop [2];
  logic        pend [2];
  int          nf [2];
  int          acc_cnt [2];
  logic        ev [2], ee [2];
  logic [31:0] ed [2];
  int          cyc_m = 0;

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        pend[d] = 1'b0; nf[d] = 0; ev[d] = 1'b0; ee[d] = 1'b0; ed[d] = 32'h0;
      end
    end else begin
      cyc_m = cyc_m + 1;
      for (int d = 0; d < 2; d++) begin
        logic [31:0] nw, rdv;
        logic er;
        ev[d] = 1'b0;
        if (rv[d] && cyc_m >= nf[d]) begin
          pop[d]  = '{we: rwe[d], addr: raddr[d], sz: rsz[d], uns: runs[d], wd: rwd[d], due: cyc_m + lat(d)};
          pend[d] = 1'b1;
          nf[d]   = cyc_m + lat(d) + 1;
          acc_cnt[d]++;
        end
        if (pend[d] && pop[d].due == cyc_m) begin
          model_op(pop[d], mm[d][pop[d].addr[5:2]], nw, rdv, er);
          if (pop[d].we && !er) mm[d][pop[d].addr[5:2]] = nw;
          ev[d] = 1'b1; ed[d] = rdv; ee[d] = er; pend[d] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("ready%0d", d), 32'(rdy[d]), 32'(rst && (cyc_m + 1 >= nf[d])));
        chk($sformatf("valid%0d", d), 32'(rvld[d]), 32'(ev[d]));
        chk($sformatf("rdata%0d", d), rdata[d], ed[d]);
        chk($sformatf("err%0d", d), 32'(rerr[d]), 32'(ee[d]));
      end
    end
  end

  task automatic issue(input int d, input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd);
    int n0, t;
    @(negedge clk); #1;
    rv[d] = 1'b1; rwe[d] = we; raddr[d] = a; rsz[d] = sz; runs[d] = u; rwd[d] = wd;
    n0 = acc_cnt[d];
    t  = 0;
    do begin @(negedge clk); t++; end while (acc_cnt[d] == n0 && t < 20);
    chk($sformatf("accept%0d", d), 32'(acc_cnt[d] - n0), 32'd1);
    #1 rv[d] = 1'b0;
  endtask

  task automatic do_req(input string nm, input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
    int w;
    issue(0, we, a, sz, u, wd);
    w = 0;
    do begin @(negedge clk); w++; end while (!rvld[0] && w < 10);
    chk({nm, "_lat"}, 32'(w), 32'd2);
    chk({nm, "_data"}, rdata[0], exp_d);
    chk({nm, "_err"}, 32'(rerr[0]), 32'(exp_e));
  endtask

  initial begin
    #1 rst = 1'b0;
    #2 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy0), 32'd0);
    chk("rst_valid", 32'(vld0), 32'd0);
    chk("rst_rdata", rd0, 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(rdy0), 32'd1);

    for (int i = 0; i < 16; i++) begin
      issue(0, 1'b1, 32'(4*i), 2'd2, 1'b0, $urandom);
      issue(1, 1'b1, 32'(4*i), 2'd2, 1'b0, (i < 4) ? 32'(32'h01010101 * (i + 1)) : $urandom);
    end

    do_req("st_w8", 1'b1, 32'h8, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req("ld_w8", 1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req("st_b9", 1'b1, 32'h9, 2'd0, 1'b0, 32'h00007F5A, 32'h0, 1'b0);
    do_req("ld_w8m", 1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 32'hDEAD5AEF, 1'b0);
    do_req("ld_b9", 1'b0, 32'h9, 2'd0, 1'b0, 32'h0, 32'h0000005A, 1'b0);
    do_req("ld_bB", 1'b0, 32'hB, 2'd0, 1'b0, 32'h0, 32'hFFFFFFDE, 1'b0);
    do_req("ld_buB", 1'b0, 32'hB, 2'd0, 1'b1, 32'h0, 32'h000000DE, 1'b0);
    do_req("ld_hA", 1'b0, 32'hA, 2'd1, 1'b0, 32'h0, 32'hFFFFDEAD, 1'b0);
    do_req("ld_w6", 1'b0, 32'h6, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    do_req("st_w0", 1'b1, 32'h0, 2'd2, 1'b0, 32'h11223344, 32'h0, 1'b0);
    do_req("st_h3", 1'b1, 32'h3, 2'd1, 1'b0, 32'h0000FFFF, 32'h0, 1'b1);
    do_req("ld_w0", 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 32'h11223344, 1'b0);
    do_req("ld_w40", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    do_req("sz_bad", 1'b0, 32'h0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1);

    @(negedge clk); #1;
    rv[1] = 1'b1; rwe[1] = 1'b0; rsz[1] = 2'd2; runs[1] = 1'b0; raddr[1] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stream_valid%0d", i), 32'(vld1), 32'd1);
      chk($sformatf("stream_data%0d", i), rd1, 32'(32'h01010101 * (i + 1)));
      #1;
      if (i < 3) raddr[1] = 32'(4 * (i + 1));
      else       rv[1] = 1'b0;
    end

    do_req("pre_rst", 1'b1, 32'h4, 2'd2, 1'b0, 32'hABCD0001, 32'h0, 1'b0);
    issue(0, 1'b1, 32'h4, 2'd2, 1'b0, 32'h12345678);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(vld0), 32'd0);
    @(negedge clk);
    chk("midrst_ready", 32'(rdy0), 32'd0);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_novalid", 32'(vld0), 32'd0);
    do_req("post_rst", 1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 32'hABCD0001, 1'b0);

    for (int n = 0; n < 400; n++) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 3) == 0) rv[d] = 1'b0;
        else begin
          rv[d]   = 1'b1;
          rwe[d]  = 1'($urandom_range(0, 1));
          runs[d] = 1'($urandom_range(0, 1));
          rwd[d]  = $urandom;
          rsz[d]  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          case ($urandom_range(0, 7))
            0:       raddr[d] = $urandom;
            1:       raddr[d] = 32'(64 + $urandom_range(0, 63));
            default: raddr[d] = 32'($urandom_range(0, 63));
          endcase
        end
      end
    end
    @(negedge clk); #1;
    rv = '0;
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
